// File: rtl/instr_word_writer_if.sv
// Bus between the loader/debug controller and the word writer, plus the
// writer's 8-bit program-memory write port.
interface instr_word_writer_if #(
    parameter int ADDR_W = 13
);
    logic              start;
    logic [15:0]       word_in;
    logic [ADDR_W-1:0] addr_in;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addr_out;
    logic [7:0]        data_out;
    logic              data_oe;
    logic              wr;

    modport master (
        output start, word_in, addr_in,
        input  busy, done, addr_out, data_out, data_oe, wr
    );

    modport slave (
        input  start, word_in, addr_in,
        output busy, done, addr_out, data_out, data_oe, wr
    );
endinterface

// File: rtl/instr_word_writer.sv
// Writes a 16-bit word to byte-wide program memory, high byte at A then low
// byte at A+1, with a setup cycle and a (WAIT+1)-cycle strobe per byte.
module instr_word_writer #(
    parameter int ADDR_W = 13,
    parameter int WAIT   = 0    // 0..15
) (
    input  logic clk,
    input  logic rst,
    instr_word_writer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HI_SETUP,
        S_HI_STROBE,
        S_LO_SETUP,
        S_LO_STROBE,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT);

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [15:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              data_oe_q, data_oe_d;
    logic              wr_q, wr_d;

    // Next-state: DONE accepts a new request exactly like IDLE so words can
    // be written back-to-back without an idle gap.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        word_d     = word_q;
        addr_d     = addr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d    = S_IDLE;
                wait_cnt_d = '0;
                if (bus.start) begin
                    word_d  = bus.word_in;
                    addr_d  = bus.addr_in;
                    state_d = S_HI_SETUP;
                end
            end
            S_HI_SETUP: state_d = S_HI_STROBE;
            S_HI_STROBE: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = '0;
                    state_d    = S_LO_SETUP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_LO_SETUP: state_d = S_LO_STROBE;
            S_LO_STROBE: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = '0;
                    state_d    = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so that the registered bus
    // shows each state's values during that state's own cycles.
    always_comb begin
        busy_d     = 1'b0;
        done_d     = 1'b0;
        addr_out_d = '0;
        data_out_d = 8'h00;
        data_oe_d  = 1'b0;
        wr_d       = 1'b0;
        case (state_d)
            S_HI_SETUP, S_HI_STROBE: begin
                busy_d     = 1'b1;
                data_oe_d  = 1'b1;
                addr_out_d = addr_d;
                data_out_d = word_d[15:8];
                wr_d       = (state_d == S_HI_STROBE);
            end
            S_LO_SETUP, S_LO_STROBE: begin
                busy_d     = 1'b1;
                data_oe_d  = 1'b1;
                addr_out_d = addr_d + 1'b1;
                data_out_d = word_d[7:0];
                wr_d       = (state_d == S_LO_STROBE);
            end
            S_DONE:  done_d = 1'b1;
            default: done_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_out_q <= '0;
            data_out_q <= 8'h00;
            data_oe_q  <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_out_q <= addr_out_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            wr_q       <= wr_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.addr_out = addr_out_q;
    assign bus.data_out = data_out_q;
    assign bus.data_oe  = data_oe_q;
    assign bus.wr       = wr_q;
endmodule

// File: tb/tb_instr_word_writer.sv
// Drives a WAIT=0 and a WAIT=3 writer with the same stimulus and checks every
// cycle against a timeline model, plus byte-level memory contents.
module tb_instr_word_writer;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   word_in;
    logic [AW-1:0] addr_in;

    always #5 clk = ~clk;

    instr_word_writer_if #(.ADDR_W(AW)) bus0 ();
    instr_word_writer_if #(.ADDR_W(AW)) bus3 ();

    assign bus0.start   = start;
    assign bus0.word_in = word_in;
    assign bus0.addr_in = addr_in;
    assign bus3.start   = start;
    assign bus3.word_in = word_in;
    assign bus3.addr_in = addr_in;

    instr_word_writer #(.ADDR_W(AW), .WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    instr_word_writer #(.ADDR_W(AW), .WAIT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // Reference: a word accepted at the edge closing cycle t0 occupies offsets
    // 1..2W+4 (busy) and pulses done at offset 2W+5.
    bit            m_act [2];
    int            m_t0  [2];
    logic [15:0]   m_word[2];
    logic [AW-1:0] m_addr[2];
    int            done_cnt[2];
    logic [7:0]    mem[2][8192];
    int            cyc;
    int            n_checks;
    int            n_fail;

    typedef struct {
        logic [15:0]   word;
        logic [AW-1:0] addr;
        logic [AW-1:0] lo_addr;
        logic [7:0]    exp_hi;
        logic [7:0]    exp_lo;
    } vec_t;
    vec_t vecs[5];

    function automatic int wv(int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit model_busy(int d, int c);
        int k;
        if (!m_act[d]) return 1'b0;
        k = c - m_t0[d];
        return (k >= 1) && (k <= 2 * wv(d) + 4);
    endfunction

    // {busy, done, oe, wr, addr[12:0], data[7:0]}
    function automatic logic [24:0] model_out(int d, int c);
        int k, w;
        logic hi;
        logic [AW-1:0] a;
        logic [7:0] dat;
        if (!m_act[d]) return '0;
        k = c - m_t0[d];
        w = wv(d);
        if (k >= 1 && k <= 2 * w + 4) begin
            hi  = (k <= w + 2);
            a   = hi ? m_addr[d] : m_addr[d] + 13'd1;
            dat = hi ? m_word[d][15:8] : m_word[d][7:0];
            return {1'b1, 1'b0, 1'b1, !(k == 1 || k == w + 3), a, dat};
        end
        if (k == 2 * w + 5) return {1'b0, 1'b1, 23'd0};
        return '0;
    endfunction

    function automatic logic [24:0] dut_out(int d);
        if (d == 0)
            return {bus0.busy, bus0.done, bus0.data_oe, bus0.wr, bus0.addr_out, bus0.data_out};
        return {bus3.busy, bus3.done, bus3.data_oe, bus3.wr, bus3.addr_out, bus3.data_out};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic step();
        logic [24:0] got;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) m_act[d] = 1'b0;
            else if (start && !model_busy(d, cyc)) begin
                m_act[d]  = 1'b1;
                m_t0[d]   = cyc;
                m_word[d] = word_in;
                m_addr[d] = addr_in;
            end
        end
        cyc++;
        #1;
        for (int d = 0; d < 2; d++) begin
            got = dut_out(d);
            check((d == 0) ? "outs_wait0" : "outs_wait3", {7'd0, got}, {7'd0, model_out(d, cyc)});
            if (got[23]) done_cnt[d]++;
            if (got[21]) mem[d][got[20:8]] = got[7:0];
        end
    endtask

    task automatic check_mem(input logic [AW-1:0] a, input logic [7:0] want);
        for (int d = 0; d < 2; d++)
            check((d == 0) ? "mem_wait0" : "mem_wait3", {24'd0, mem[d][a]}, {24'd0, want});
    endtask

    task automatic write_word(input logic [15:0] w, input logic [AW-1:0] a);
        word_in = w;
        addr_in = a;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    initial begin
        int d0[2];
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0;
            m_t0[d] = 0;
            done_cnt[d] = 0;
        end
        rst = 1'b1; start = 1'b0; word_in = '0; addr_in = '0;

        vecs[0] = '{16'hA5C3, 13'h0040, 13'h0041, 8'hA5, 8'hC3};
        vecs[1] = '{16'h1234, 13'h0100, 13'h0101, 8'h12, 8'h34};
        vecs[2] = '{16'h0000, 13'h00AA, 13'h00AB, 8'h00, 8'h00};
        vecs[3] = '{16'hFFFF, 13'h1FFE, 13'h1FFF, 8'hFF, 8'hFF};
        vecs[4] = '{16'h7E81, 13'h1FFF, 13'h0000, 8'h7E, 8'h81};

        // Reset, then a quiet idle stretch.
        repeat (2) step();
        rst = 1'b0;
        repeat (10) step();

        // Single words from the table.
        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            write_word(vecs[i].word, vecs[i].addr);
            repeat (12) step();
            check_mem(vecs[i].addr, vecs[i].exp_hi);
            check_mem(vecs[i].lo_addr, vecs[i].exp_lo);
            for (int d = 0; d < 2; d++)
                check("done_once", done_cnt[d] - d0[d], 1);
        end

        // Wrap to address 0, then a second word requested in the DONE cycle.
        d0 = done_cnt;
        word_in = 16'hBEEF; addr_in = 13'h1FFF; start = 1'b1;
        step();
        word_in = 16'h0102; addr_in = 13'h0010;
        repeat (11) step();
        start = 1'b0;
        repeat (14) step();
        check_mem(13'h1FFF, 8'hBE);
        check_mem(13'h0000, 8'hEF);
        check_mem(13'h0010, 8'h01);
        check_mem(13'h0011, 8'h02);
        check("b2b_done_w0", done_cnt[0] - d0[0], 3);
        check("b2b_done_w3", done_cnt[1] - d0[1], 2);

        // Start pulse during HI_STROBE is ignored.
        d0 = done_cnt;
        write_word(16'h5A5A, 13'h0200);
        step();
        word_in = 16'hFFFF; addr_in = 13'h0200; start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        check_mem(13'h0200, 8'h5A);
        check_mem(13'h0201, 8'h5A);
        for (int d = 0; d < 2; d++)
            check("busy_start_done", done_cnt[d] - d0[d], 1);

        // Reset mid-word abandons it without a done pulse.
        d0 = done_cnt;
        write_word(16'h6789, 13'h0300);
        repeat (3) step();
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        repeat (12) step();
        for (int d = 0; d < 2; d++)
            check("rst_no_done", done_cnt[d] - d0[d], 0);
        write_word(16'h4321, 13'h0301);
        repeat (12) step();
        check_mem(13'h0301, 8'h43);
        check_mem(13'h0302, 8'h21);

        // Random traffic with occasional resets, checked cycle by cycle.
        repeat (500) begin
            start   = ($urandom_range(0, 3) == 0);
            word_in = 16'($urandom);
            addr_in = AW'($urandom);
            rst     = ($urandom_range(0, 59) == 0);
            step();
        end
        rst = 1'b0; start = 1'b0;
        repeat (12) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
